tdc_sweep_ctrl: RTL and testbench
=================================

TDC_SWEEP_CTRL -- requirements
Module: tdc_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: idle cycles between launch and capture, legal range 1..255.
REQ-002 Parameter SAMPLES_LOG2, default 3: log2 of the number of samples accumulated per delay setting, legal range 0..8.
REQ-003 Timing: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  single-cycle sweep request; sampled only in IDLE.
REQ-007 delay_min_i  in  5  first stop-delay code of the sweep; latched on accepted start.
REQ-008 delay_max_i  in  5  last stop-delay code of the sweep; latched on accepted start.
REQ-009 term_i  in  8  asynchronous thermometer code from the delay-line taps, bit 0 = first tap.
REQ-010 delay_en_o  out  5  stop-delay enable code that drives the variable delay element.
REQ-011 trig_o  out  1  launch strobe for the start/stop input stages.
REQ-012 busy_o  out  1  high in every state except IDLE.
REQ-013 done_o  out  1  single-cycle pulse at sweep end.
REQ-014 res_valid_o  out  1  result-available flag.
REQ-015 res_ready_i  in  1  result consumer ready.
REQ-016 res_delay_o  out  5  delay code the result belongs to.
REQ-017 res_sum_o  out  4+SAMPLES_LOG2  sum of tap counts over the samples.
REQ-018 res_err_o  out  1  bubble seen in any sample of this setting.

Function
REQ-019 term_i shall pass through a 2-flop synchronizer; all captures shall use the second-stage value.
REQ-020 The FSM shall have the states IDLE, ARM, SETTLE, CAPTURE, REPORT and DONE.
REQ-021 IDLE: when start_i=1 and delay_min_i<=delay_max_i, the block shall latch both bounds, set delay to delay_min_i, clear the accumulator and error flag, and go to ARM.
REQ-022 IDLE: when start_i=1 and delay_min_i>delay_max_i, the block shall go to DONE with no result produced.
REQ-023 ARM shall last exactly 1 cycle with trig_o=1, then go to SETTLE; trig_o shall be 0 in every other state.
REQ-024 SETTLE shall last exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-025 CAPTURE (1 cycle): the synchronized code's ones count (0..8) shall be added to the accumulator.
REQ-026 CAPTURE: the error flag shall be set if the code is not of the form 0...01...1 (ones contiguous from bit 0); the ones count shall still be added.
REQ-027 CAPTURE: after sample 2^SAMPLES_LOG2 the block shall go to REPORT, otherwise to ARM; the sample counter width shall be SAMPLES_LOG2+1 bits.
REQ-028 REPORT: res_valid_o=1 with res_delay_o, res_sum_o and res_err_o stable until the cycle in which res_ready_i=1.
REQ-029 REPORT handshake, delay<delay_max: delay+1, accumulator/error/sample counter cleared, go to ARM.
REQ-030 REPORT handshake, delay==delay_max: go to DONE; the delay code shall never wrap (max=31 terminates).
REQ-031 DONE shall last 1 cycle with done_o=1, then go to IDLE.
REQ-032 delay_en_o shall equal the current delay code in ARM/SETTLE/CAPTURE/REPORT and 0 in IDLE/DONE.
REQ-033 start_i outside IDLE shall be ignored.
REQ-034 Per-sample period shall be 2+SETTLE_CYCLES cycles; the accumulator shall not overflow (max 8*2^SAMPLES_LOG2 fits the width).

Reset
REQ-035 rst=1 shall force IDLE from any state on the next edge, abandoning a sweep in progress with no done_o pulse.
REQ-036 rst=1 shall clear trig_o, busy_o, done_o, res_valid_o, delay_en_o, res_delay_o, res_sum_o, res_err_o, the accumulator, the counters and the synchronizer flops to 0.

Verification
REQ-037 Defaults, min=2, max=3, term_i=8'h0F constant, res_ready_i=1 -> two results (2,32,0) then (3,32,0); 8 trig_o pulses spaced 6 cycles per setting; then done_o.
REQ-038 min=max=7, term_i=8'h0B -> one result: delay 7, sum 24, err 1.
REQ-039 min=5, max=4 -> done_o exactly 2 cycles after start_i, no res_valid_o, no trig_o.
REQ-040 Hold res_ready_i=0 for 10 cycles in REPORT -> outputs held stable, no trig_o, delay_en_o unchanged; the sweep proceeds on ready.
REQ-041 min=30, max=31 -> results for 30 and 31 only, then done_o, no wrap to 0.
REQ-042 rst=1 during SETTLE of setting 1 -> next cycle IDLE with all outputs 0; a new start_i gives a clean sweep.

Source files
------------

// File: rtl/tdc_sweep_ctrl.sv
// Delay-line TDC sweep controller: steps the stop-delay code from min to max,
// accumulates 2^SAMPLES_LOG2 synchronized thermometer samples per code and reports each sum.
module tdc_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES_LOG2  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [4:0]                delay_min_i,
  input  logic [4:0]                delay_max_i,
  input  logic [7:0]                term_i,
  output logic [4:0]                delay_en_o,
  output logic                      trig_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [4:0]                res_delay_o,
  output logic [4+SAMPLES_LOG2-1:0] res_sum_o,
  output logic                      res_err_o
);

  localparam int unsigned SUM_W = 4 + SAMPLES_LOG2;
  localparam int unsigned CNT_W = SAMPLES_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES   = CNT_W'(1 << SAMPLES_LOG2);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ARM, SETTLE, CAPTURE, REPORT, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         term_s1, term_s2;
  logic [4:0]         delay_q, delay_d;
  logic [4:0]         dmax_q, dmax_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   smp_q, smp_d;
  logic [7:0]         set_q, set_d;
  logic [3:0]         ones;
  logic [7:0]         term_inc;
  logic               bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      term_s1 <= '0;
      term_s2 <= '0;
      delay_q <= '0;
      dmax_q  <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      smp_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      term_s1 <= term_i;
      term_s2 <= term_s1;
      delay_q <= delay_d;
      dmax_q  <= dmax_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      smp_q   <= smp_d;
      set_q   <= set_d;
    end
  end

  // A valid code has ones contiguous from bit 0, i.e. code & (code+1) == 0.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < 8; i++) ones = ones + {3'b000, term_s2[i]};
    term_inc = term_s2 + 8'd1;
    bubble   = |(term_s2 & term_inc);
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    dmax_d  = dmax_q;
    acc_d   = acc_q;
    err_d   = err_q;
    smp_d   = smp_q;
    set_d   = set_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (delay_min_i <= delay_max_i) begin
            delay_d = delay_min_i;
            dmax_d  = delay_max_i;
            acc_d   = '0;
            err_d   = 1'b0;
            smp_d   = '0;
            state_d = ARM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ARM: begin
        set_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (set_q == SETTLE_LAST) state_d = CAPTURE;
        else                      set_d   = set_q + 8'd1;
      end
      CAPTURE: begin
        acc_d = acc_q + SUM_W'(ones);
        if (bubble) err_d = 1'b1;
        smp_d   = smp_q + 1'b1;
        state_d = (smp_d == N_SAMPLES) ? REPORT : ARM;
      end
      REPORT: begin
        // delay never exceeds dmax, so inequality alone keeps the code from wrapping.
        if (res_ready_i) begin
          if (delay_q != dmax_q) begin
            delay_d = delay_q + 5'd1;
            acc_d   = '0;
            err_d   = 1'b0;
            smp_d   = '0;
            state_d = ARM;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign trig_o      = (state_q == ARM);
  assign done_o      = (state_q == DONE);
  assign res_valid_o = (state_q == REPORT);
  assign delay_en_o  = (state_q == IDLE || state_q == DONE) ? '0 : delay_q;
  assign res_delay_o = delay_q;
  assign res_sum_o   = acc_q;
  assign res_err_o   = err_q;

endmodule

// File: tb/tb_tdc_sweep_ctrl.sv
// Scoreboard bench for tdc_sweep_ctrl: directed sweeps push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_tdc_sweep_ctrl;

  localparam int unsigned SL    = 3;
  localparam int unsigned SUM_W = 4 + SL;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [4:0]       delay_min_i = '0;
  logic [4:0]       delay_max_i = '0;
  logic [7:0]       term_i = '0;
  logic [4:0]       delay_en_o;
  logic             trig_o, busy_o, done_o, res_valid_o;
  logic             res_ready_i = 1'b1;
  logic [4:0]       res_delay_o;
  logic [SUM_W-1:0] res_sum_o;
  logic             res_err_o;

  tdc_sweep_ctrl #(.SETTLE_CYCLES(4), .SAMPLES_LOG2(SL)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .delay_min_i(delay_min_i), .delay_max_i(delay_max_i), .term_i(term_i),
    .delay_en_o(delay_en_o), .trig_o(trig_o), .busy_o(busy_o), .done_o(done_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_delay_o(res_delay_o), .res_sum_o(res_sum_o), .res_err_o(res_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       d;
    logic [SUM_W-1:0] s;
    logic             e;
  } res_t;

  res_t exp_q[$];
  res_t mon_r;
  int vectors = 0, miscompares = 0;
  int cyc = 0, trig_cnt = 0, gap6_cnt = 0, last_trig = -1000, done_cnt = 0, res_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && res_valid_o && res_ready_i) begin
      res_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got delay %0d sum %0d err %0d, expected none",
                 res_delay_o, res_sum_o, res_err_o);
      end else begin
        mon_r = exp_q.pop_front();
        check("res_delay", int'(res_delay_o), int'(mon_r.d));
        check("res_sum",   int'(res_sum_o),   int'(mon_r.s));
        check("res_err",   int'(res_err_o),   int'(mon_r.e));
      end
    end
  end

  // Strobe monitor
  always @(negedge clk) begin
    cyc++;
    if (trig_o) begin
      trig_cnt++;
      if (cyc - last_trig == 6) gap6_cnt++;
      last_trig = cyc;
    end
    if (done_o) done_cnt++;
  end

  task automatic push(input int d, input int s, input int e);
    res_t r;
    r.d = 5'(d);
    r.s = SUM_W'(s);
    r.e = 1'(e);
    exp_q.push_back(r);
  endtask

  task automatic go(input int mn, input int mx);
    @(posedge clk); #1;
    delay_min_i = 5'(mn);
    delay_max_i = 5'(mx);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < budget);
    check(name, int'(done_o), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, t0, r0, d0;
    logic ok;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({busy_o, trig_o, done_o, res_valid_o, delay_en_o, res_delay_o, res_sum_o, res_err_o}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Two settings, clean code 0x0F
    term_i = 8'h0F; res_ready_i = 1'b1;
    idle(3);
    trig_cnt = 0; gap6_cnt = 0; last_trig = -1000; d0 = done_cnt;
    push(2, 32, 0); push(3, 32, 0);
    go(2, 3);
    wait_done("sweep23_done", 400, n);
    check("sweep23_trig_count", trig_cnt, 16);
    check("sweep23_trig_gap6", gap6_cnt, 14);
    idle(2);
    check("sweep23_done_pulses", done_cnt - d0, 1);

    // Single setting with a bubble code 0x0B
    term_i = 8'h0B;
    idle(3);
    push(7, 24, 1);
    go(7, 7);
    wait_done("single7_done", 200, n);

    // Inverted range: immediate DONE, nothing else
    idle(2);
    t0 = trig_cnt; r0 = res_cnt;
    go(5, 4);
    wait_done("badrange_done", 5, n);
    check("badrange_done_latency_ok", int'(n <= 2), 1);
    @(negedge clk);
    check("badrange_done_single_cycle", int'(done_o), 0);
    check("badrange_no_trig", trig_cnt - t0, 0);
    check("badrange_no_result", res_cnt - r0, 0);

    // Back-pressure in REPORT
    term_i = 8'hFF; res_ready_i = 1'b0;
    idle(3);
    push(10, 64, 0);
    go(10, 10);
    n = 0;
    while (!res_valid_o && n < 200) begin @(negedge clk); n++; end
    check("hold_valid_reached", int'(res_valid_o), 1);
    t0 = trig_cnt; ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok &= (res_valid_o == 1'b1) && (res_delay_o == 5'd10) && (res_sum_o == SUM_W'(64))
            && (res_err_o == 1'b0) && (delay_en_o == 5'd10);
    end
    check("hold_outputs_stable", int'(ok), 1);
    check("hold_no_trig", trig_cnt - t0, 0);
    @(posedge clk); #1 res_ready_i = 1'b1;
    wait_done("hold_done", 50, n);

    // Top of range: 30, 31, then stop
    term_i = 8'h01;
    idle(3);
    r0 = res_cnt;
    push(30, 8, 0); push(31, 8, 0);
    go(30, 31);
    wait_done("top_done", 300, n);
    idle(20);
    check("top_result_count", res_cnt - r0, 2);
    check("top_idle_delay_en", int'(delay_en_o), 0);
    check("top_idle_busy", int'(busy_o), 0);

    // Reset in SETTLE of the first setting
    term_i = 8'h07;
    idle(3);
    d0 = done_cnt;
    go(1, 2);
    @(posedge clk); #1;
    check("abort_in_settle_delay_en", int'(delay_en_o), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_outputs_zero",
          int'({busy_o, trig_o, done_o, res_valid_o, delay_en_o, res_delay_o, res_sum_o, res_err_o}), 0);
    idle(10);
    check("abort_no_done", done_cnt - d0, 0);
    push(1, 24, 0);
    go(1, 1);
    wait_done("restart_done", 200, n);

    idle(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
